// File: rtl/mem_arbiter.sv
// Shared-memory arbiter and line-fill sequencer for the I-cache, the D-cache and the
// write-through store path. It issues the eight word reads of a line and steers the returning data.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        st_req,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_data_we,
    output logic        d_data_we,
    output logic        i_tag_we,
    output logic        d_tag_we,
    output logic        i_stall,
    output logic        d_stall,
    output logic        st_ack
);

    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 16;
    localparam int unsigned WORDS  = 8;
    localparam int unsigned CW     = $clog2(WORDS);
    localparam int unsigned LINE_W = AW - 4;
    localparam logic        TGT_I  = 1'b0;
    localparam logic        TGT_D  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        TAG,
        STORE
    } state_t;

    state_t              state, state_n;
    logic [LINE_W-1:0]   line_q;
    logic [CW-1:0]       icnt, rcnt;
    logic                tgt, last;
    logic [AW-1:0]       st_addr_q;
    logic [DW-1:0]       st_data_q;

    logic                ld_fill, ld_store, fill_tgt;
    logic                icnt_inc, ret;
    logic                upd_last, last_n;
    logic                d_pend, last_word;

    // Byte offset within the line never reaches memory: fills always start at word 0.
    logic unused_ok;
    assign unused_ok = &{1'b0, i_addr[3:0], d_addr[3:0]};

    assign d_pend    = d_req | st_req;
    assign last_word = mem_data_valid && (rcnt == CW'(WORDS - 1));

    assign i_stall   = i_req;
    assign d_stall   = d_pend;
    assign fill_data = mem_rdata;
    assign fill_word = rcnt;

    // State register, counters and latched request context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            line_q    <= '0;
            icnt      <= '0;
            rcnt      <= '0;
            tgt       <= TGT_I;
            last      <= TGT_D;
            st_addr_q <= '0;
            st_data_q <= '0;
        end else begin
            state <= state_n;
            if (ld_fill) begin
                line_q <= (fill_tgt == TGT_D) ? d_addr[AW-1:4] : i_addr[AW-1:4];
                tgt    <= fill_tgt;
                icnt   <= '0;
                rcnt   <= '0;
            end else begin
                if (icnt_inc) icnt <= icnt + CW'(1);
                if (ret)      rcnt <= rcnt + CW'(1);
            end
            if (ld_store) begin
                st_addr_q <= st_addr;
                st_data_q <= st_data;
            end
            if (upd_last) last <= last_n;
        end
    end

    // Arbitration, sequencing and output decode.
    always_comb begin
        state_n   = state;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_data_we = 1'b0;
        d_data_we = 1'b0;
        i_tag_we  = 1'b0;
        d_tag_we  = 1'b0;
        st_ack    = 1'b0;
        ld_fill   = 1'b0;
        ld_store  = 1'b0;
        fill_tgt  = tgt;
        icnt_inc  = 1'b0;
        ret       = 1'b0;
        upd_last  = 1'b0;
        last_n    = last;

        case (state)
            IDLE: begin
                // On a tie the side not served last wins.
                if (i_req && (!d_pend || last == TGT_D)) begin
                    ld_fill  = 1'b1;
                    fill_tgt = TGT_I;
                    state_n  = ISSUE;
                end else if (d_req) begin
                    ld_fill  = 1'b1;
                    fill_tgt = TGT_D;
                    state_n  = ISSUE;
                end else if (st_req) begin
                    ld_store = 1'b1;
                    state_n  = STORE;
                end
            end
            ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = {line_q, icnt, 1'b0};
                icnt_inc = 1'b1;
                ret      = mem_data_valid;
                if (icnt == CW'(WORDS - 1)) state_n = last_word ? TAG : DRAIN;
            end
            DRAIN: begin
                ret = mem_data_valid;
                if (last_word) state_n = TAG;
            end
            TAG: begin
                i_tag_we = (tgt == TGT_I);
                d_tag_we = (tgt == TGT_D);
                upd_last = 1'b1;
                last_n   = tgt;
                state_n  = IDLE;
            end
            STORE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = st_addr_q;
                mem_wdata = st_data_q;
                st_ack    = 1'b1;
                upd_last  = 1'b1;
                last_n    = TGT_D;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase

        i_data_we = ret && (tgt == TGT_I);
        d_data_we = ret && (tgt == TGT_D);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level grant model fills expectation queues,
// and a negedge monitor pops and compares every bus, fill and tag event.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, st_req = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, st_addr = '0, st_data = '0;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, fill_data;
    logic [2:0]  fill_word;
    logic        i_data_we, d_data_we, i_tag_we, d_tag_we, i_stall, d_stall, st_ack;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_data_we(i_data_we), .d_data_we(d_data_we),
        .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
        .i_stall(i_stall), .d_stall(d_stall), .st_ack(st_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: fixed-latency read pipe, data derived from the address.
    logic [15:0]    salt = 16'h5A3C;
    logic [LAT-1:0] vpipe = '0;
    logic [15:0]    apipe [LAT];
    logic           inject = 1'b0;

    function automatic logic [15:0] mdat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ salt;
    endfunction

    always @(posedge clk) begin
        vpipe    <= {vpipe[LAT-2:0], mem_en & ~mem_wr};
        apipe[0] <= mem_addr;
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end

    assign mem_data_valid = vpipe[LAT-1] | inject;
    assign mem_rdata      = inject ? 16'hDEAD : mdat(apipe[LAT-1]);

    int n_checks = 0, n_errs = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Expectation queues: read addresses, {tgt,word,data} fills, completion order (0=I,1=D,2=store), stores.
    logic [15:0] q_rd[$];
    logic [19:0] q_fill[$];
    int          q_ord[$];
    logic [31:0] q_st[$];

    int t_rd = -1, t_we = -1, t_itag = -1, t_dtag = -1, t_st = -1, t_raise = 0;
    int n_itag = 0, n_dtag = 0, n_sack = 0, n_wr = 0;
    int seen_i = 0, seen_d = 0, seen_s = 0;

    always @(negedge clk) begin
        chk("i_stall", 32'(i_stall), 32'(i_req));
        chk("d_stall", 32'(d_stall), 32'(d_req | st_req));
        chk("st_ack_vs_write", 32'(st_ack), 32'(mem_en & mem_wr));
        if (!mem_en) chk("idle_bus", {15'd0, mem_wr, mem_addr | mem_wdata}, 32'd0);
        if (mem_en && !mem_wr) begin
            if (t_rd < 0) t_rd = cyc;
            chk("rd_expected", 32'(q_rd.size() > 0), 32'd1);
            if (q_rd.size() > 0) chk("rd_addr", 32'(mem_addr), 32'(q_rd.pop_front()));
        end
        if (mem_en && mem_wr) begin
            t_st = cyc;
            n_wr++;
            n_sack++;
            chk("st_expected", 32'(q_st.size() > 0 && q_ord.size() > 0), 32'd1);
            if (q_st.size() > 0 && q_ord.size() > 0) begin
                chk("st_order", 32'(q_ord.pop_front()), 32'd2);
                chk("st_addr_data", {mem_addr, mem_wdata}, q_st.pop_front());
            end
        end
        if (i_data_we || d_data_we) begin
            if (t_we < 0) t_we = cyc;
            chk("we_onehot", 32'(i_data_we & d_data_we), 32'd0);
            chk("we_needs_valid", 32'(mem_data_valid), 32'd1);
            chk("fill_expected", 32'(q_fill.size() > 0), 32'd1);
            if (q_fill.size() > 0) begin
                logic [19:0] e;
                e = q_fill.pop_front();
                chk("fill_tgt", 32'(d_data_we), 32'(e[19]));
                chk("fill_word", 32'(fill_word), 32'(e[18:16]));
                chk("fill_data", 32'(fill_data), 32'(e[15:0]));
            end
        end
        if (i_tag_we || d_tag_we) begin
            chk("tag_onehot", 32'(i_tag_we & d_tag_we), 32'd0);
            if (i_tag_we) begin t_itag = cyc; n_itag++; end
            if (d_tag_we) begin t_dtag = cyc; n_dtag++; end
            chk("tag_expected", 32'(q_ord.size() > 0), 32'd1);
            if (q_ord.size() > 0) chk("tag_order", 32'(d_tag_we), 32'(q_ord.pop_front()));
        end
    end

    // Advance one cycle; requesters drop their request the cycle after being served.
    task automatic tick();
        @(posedge clk);
        #1;
        if (n_itag != seen_i) begin i_req = 1'b0; seen_i = n_itag; end
        if (n_dtag != seen_d) begin d_req = 1'b0; seen_d = n_dtag; end
        if (n_sack != seen_s) begin st_req = 1'b0; seen_s = n_sack; end
    endtask

    bit m_last_d = 1'b1;

    task automatic push_fill(input bit tg, input logic [15:0] a);
        logic [15:0] base, wa;
        base = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            wa = base + 16'(2 * k);
            q_rd.push_back(wa);
            q_fill.push_back({tg, 3'(k), mdat(wa)});
        end
        q_ord.push_back(tg ? 1 : 0);
        m_last_d = tg;
    endtask

    task automatic push_store(input logic [15:0] a, input logic [15:0] dt);
        q_ord.push_back(2);
        q_st.push_back({a, dt});
        m_last_d = 1'b1;
    endtask

    // Grant order from the arbitration rules; a late store joins after the first grant.
    task automatic model(input bit pi_in, input bit pd_in, input bit ps, input bit s_late,
                         input logic [15:0] ia, input logic [15:0] da,
                         input logic [15:0] sa, input logic [15:0] sd);
        bit pi, pd, sp, sl;
        pi = pi_in; pd = pd_in; sp = ps && !s_late; sl = ps && s_late;
        while (pi || pd || sp || sl) begin
            if (pi && (!(pd || sp) || m_last_d)) begin push_fill(1'b0, ia); pi = 1'b0; end
            else if (pd) begin push_fill(1'b1, da); pd = 1'b0; end
            else if (sp) begin push_store(sa, sd); sp = 1'b0; end
            if (sl) begin sp = 1'b1; sl = 1'b0; end
        end
    endtask

    task automatic run_scn(input bit pi, input bit pd, input bit ps, input int sdly,
                           input logic [15:0] ia, input logic [15:0] da,
                           input logic [15:0] sa, input logic [15:0] sd);
        bit done;
        model(pi, pd, ps, sdly > 0, ia, da, sa, sd);
        i_addr = ia; d_addr = da; st_addr = sa; st_data = sd;
        i_req = pi; d_req = pd; st_req = ps && (sdly == 0);
        t_raise = cyc;
        done = 1'b0;
        for (int n = 1; n <= 300 && !done; n++) begin
            tick();
            if (ps && n == sdly) st_req = 1'b1;
            if (!i_req && !d_req && !st_req && n >= sdly && q_ord.size() == 0 &&
                q_rd.size() == 0 && q_fill.size() == 0) done = 1'b1;
        end
        chk("scenario_complete", 32'(done), 32'd1);
        i_req = 1'b0; d_req = 1'b0; st_req = 1'b0;
    endtask

    task automatic clr_times();
        t_rd = -1; t_we = -1; t_itag = -1; t_dtag = -1; t_st = -1;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_bus"}, {mem_en, mem_wr, mem_addr[13:0], mem_wdata}, 32'd0);
        chk({nm, "_ctl"}, {24'd0, fill_word, i_data_we, d_data_we, i_tag_we, d_tag_we, st_ack}, 32'd0);
    endtask

    initial begin
        int wr0;
        bit pi, pd, ps;
        int sd;
        salt = 16'($urandom);
        #1;
        chk_quiet("reset");
        chk("reset_addr_hi", 32'(mem_addr[15:14]), 32'd0);
        i_req = 1'b1;
        #1;
        chk("reset_i_stall_follows", 32'(i_stall), 32'd1);
        i_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Tie right after reset: I first, D fill starts at the IDLE after I's tag.
        clr_times();
        run_scn(1'b1, 1'b1, 1'b0, 0, 16'h2468, 16'h8ACE, 16'h0, 16'h0);
        chk("tie_i_first", 32'(t_itag < t_dtag), 32'd1);
        chk("tie_gap", 32'(t_dtag - t_itag), 32'(10 + LAT));

        // Isolated I miss: fixed cycle positions relative to the request.
        clr_times();
        run_scn(1'b1, 1'b0, 1'b0, 0, 16'h1236, 16'h0, 16'h0, 16'h0);
        chk("i_first_read", 32'(t_rd - t_raise), 32'd1);
        chk("i_first_we", 32'(t_we - t_raise), 32'(1 + LAT));
        chk("i_tag_cycle", 32'(t_itag - t_raise), 32'(9 + LAT));

        // Single store.
        clr_times();
        wr0 = n_wr;
        run_scn(1'b0, 1'b0, 1'b1, 0, 16'h0, 16'h0, 16'h0040, 16'hBEEF);
        chk("st_cycle", 32'(t_st - t_raise), 32'd1);
        chk("st_count", 32'(n_wr - wr0), 32'd1);

        // Store raised during an I fill waits for the tag write.
        clr_times();
        run_scn(1'b1, 1'b0, 1'b1, 3, 16'h5550, 16'h0, 16'h0102, 16'hCAFE);
        chk("st_after_tag", 32'(t_st - t_itag), 32'd2);

        // Spurious valid while idle.
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("spurious_fill_word", 32'(fill_word), 32'd0);

        // Reset at cycle 6 of a D fill.
        push_fill(1'b1, 16'h7770);
        d_addr = 16'h7770;
        d_req = 1'b1;
        repeat (6) tick();
        rst = 1'b0;
        d_req = 1'b0;
        #1;
        chk_quiet("midfill_reset");
        q_rd.delete(); q_fill.delete(); q_ord.delete(); q_st.delete();
        m_last_d = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        repeat (8) tick();
        chk("post_reset_fill_word", 32'(fill_word), 32'd0);
        run_scn(1'b0, 1'b1, 1'b0, 0, 16'h0, 16'h4A5C, 16'h0, 16'h0);

        // Randomized mixes of simultaneous and staggered requests.
        for (int r = 0; r < 25; r++) begin
            pi = 1'($urandom_range(0, 1));
            pd = 1'($urandom_range(0, 1));
            ps = 1'($urandom_range(0, 1));
            if (!pi && !pd && !ps) pd = 1'b1;
            sd = (ps && (pi || pd) && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
            run_scn(pi, pd, ps, sd, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2 * LAT) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
